// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, mid-bit sampling timed from the start edge,
// LSB-first payload, one stop bit. Emits a one-cycle done or frame_err pulse per frame.
module uart_rx #(
  parameter int BIT_RATE     = 115200,
  parameter int CLK_FREQ     = 10_000_000,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_i_serial_data,
  output logic [PAYLOAD_BITS-1:0] io_o_data,
  output logic                    io_o_rx_done,
  output logic                    io_o_rx_busy,
  output logic                    io_o_frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BIT_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(PAYLOAD_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAYLOAD_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                  state_q;
  logic                    rx_s1_q, rx_s2_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [BIT_W-1:0]        bit_q;
  logic [PAYLOAD_BITS-1:0] shift_q, data_q;
  logic                    done_q, ferr_q, busy_q;
  // Set by a framing error: the line may be held low (break), so the
  // receiver must see it return high before it can detect a new start bit.
  logic                    brk_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      rx_s1_q <= io_i_serial_data;
      rx_s2_q <= rx_s1_q;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      cnt_q   <= cnt_q + CNT_W'(1);
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (brk_q) begin
            if (rx_s2_q) brk_q <= 1'b0;
          end else if (!rx_s2_q) begin
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            if (rx_s2_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
              bit_q   <= '0;
            end
          end
        end
        DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            shift_q <= {rx_s2_q, shift_q[PAYLOAD_BITS-1:1]};
            bit_q   <= bit_q + BIT_W'(1);
            if (bit_q == LAST_BIT) state_q <= STOP;
          end
        end
        STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (rx_s2_q) begin
              data_q <= shift_q;
              done_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
              brk_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io_o_data      = data_q;
  assign io_o_rx_done   = done_q;
  assign io_o_rx_busy   = busy_q;
  assign io_o_frame_err = ferr_q;

endmodule
